// File: rtl/tow_scoreboard.sv
// Tug-of-war score tracker: one-hot position walks away from home on scores,
// with round counting and a sticky match-won state.
module tow_scoreboard #(
  parameter int N_POS      = 4,
  parameter int WIN_ROUNDS = 3,
  parameter int DECAY_MODE = 1,
  parameter int RW         = $clog2(WIN_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       idle,
  input  logic             increment,
  input  logic             decrement,
  output logic [N_POS-1:0] pattern,
  output logic             vulnerable,
  output logic             round_win,
  output logic [RW-1:0]    rounds,
  output logic             match_won
);

  localparam int PW = $clog2(N_POS + 1);
  localparam logic [PW-1:0] TOP  = PW'(N_POS);
  localparam logic [RW-1:0] RMAX = RW'(WIN_ROUNDS);

  typedef enum logic [1:0] {
    PLAY,
    WIN,
    MATCH
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_nx;
  logic [RW-1:0] rnd;
  logic [RW-1:0] rnd_nx;
  logic          up;
  logic          dn;

  // In decay mode any non-scoring cycle is a retreat.
  always_comb begin
    if (DECAY_MODE != 0) begin
      up = increment;
      dn = ~increment;
    end else begin
      up = increment & ~decrement;
      dn = decrement & ~increment;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PLAY;
      pos   <= '0;
      rnd   <= '0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
      rnd   <= rnd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    rnd_nx   = rnd;
    unique case (state)
      PLAY: begin
        if (idle == 2'b00) begin
          if (up) begin
            if (pos == TOP) begin
              state_nx = WIN;
              rnd_nx   = rnd + RW'(1);
            end else begin
              pos_nx = pos + PW'(1);
            end
          end else if (dn && pos != '0) begin
            pos_nx = pos - PW'(1);
          end
        end
      end
      WIN: begin
        if (rnd == RMAX) begin
          state_nx = MATCH;
        end else begin
          state_nx = PLAY;
          pos_nx   = '0;
        end
      end
      MATCH: state_nx = MATCH;
      default: state_nx = PLAY;
    endcase
  end

  // First LED is the MSB; WIN and MATCH show the last LED.
  always_comb begin
    pattern = '0;
    if (state != PLAY) begin
      pattern[0] = 1'b1;
    end else begin
      for (int i = 1; i <= N_POS; i++) begin
        if (pos == PW'(i)) pattern[N_POS-i] = 1'b1;
      end
    end
  end

  assign vulnerable = (state == PLAY) && (pos <= PW'(1));
  assign round_win  = (state == WIN);
  assign match_won  = (state == MATCH);
  assign rounds     = rnd;

endmodule

// File: tb/tb_tow_scoreboard.sv
// Random + directed bench for tow_scoreboard, two configurations
// checked every cycle against a behavioural model.
module tb_tow_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       increment;
  logic       decrement;
  logic [1:0] idle;

  always #5 clk = ~clk;

  logic [3:0] pa;
  logic       va, rwa, ma;
  logic [1:0] ra;
  logic [5:0] pb;
  logic       vb, rwb, mb;
  logic [1:0] rb;

  tow_scoreboard #(.N_POS(4), .WIN_ROUNDS(2), .DECAY_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .idle(idle),
    .increment(increment), .decrement(decrement),
    .pattern(pa), .vulnerable(va), .round_win(rwa),
    .rounds(ra), .match_won(ma)
  );

  tow_scoreboard #(.N_POS(6), .WIN_ROUNDS(3), .DECAY_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .idle(idle),
    .increment(increment), .decrement(decrement),
    .pattern(pb), .vulnerable(vb), .round_win(rwb),
    .rounds(rb), .match_won(mb)
  );

  typedef struct {
    int pos;
    int rnd;
    bit win;
    bit match;
  } m_t;

  m_t ms_a;
  m_t ms_b;
  bit armed = 1'b0;
  int checks = 0;
  int errors = 0;

  function automatic m_t nxt(m_t s, int n, int w, bit decay,
                             bit rst, bit inc, bit dec, logic [1:0] id);
    m_t r;
    bit up, dn;
    r = s;
    up = decay ? inc : (inc && !dec);
    dn = decay ? !inc : (dec && !inc);
    if (rst) begin
      r.pos = 0; r.rnd = 0; r.win = 0; r.match = 0;
    end else if (s.match) begin
      r = s;
    end else if (s.win) begin
      r.win = 0;
      if (s.rnd == w) r.match = 1;
      else r.pos = 0;
    end else if (id == 2'b00) begin
      if (up) begin
        if (s.pos < n) r.pos = s.pos + 1;
        else begin r.win = 1; r.rnd = s.rnd + 1; end
      end else if (dn && s.pos > 0) begin
        r.pos = s.pos - 1;
      end
    end
    return r;
  endfunction

  function automatic int exp_pat(m_t s, int n);
    if (s.win || s.match) return 1;
    if (s.pos == 0) return 0;
    return 1 << (n - s.pos);
  endfunction

  function automatic int exp_vul(m_t s);
    return (!s.win && !s.match && s.pos <= 1) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ms_a = nxt(ms_a, 4, 2, 1'b0, reset, increment, decrement, idle);
    ms_b = nxt(ms_b, 6, 3, 1'b1, reset, increment, decrement, idle);
    if (reset) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("a_pattern", 32'(pa), exp_pat(ms_a, 4));
      chk("a_vulnerable", 32'(va), exp_vul(ms_a));
      chk("a_round_win", 32'(rwa), 32'(ms_a.win));
      chk("a_rounds", 32'(ra), ms_a.rnd);
      chk("a_match_won", 32'(ma), 32'(ms_a.match));
      chk("b_pattern", 32'(pb), exp_pat(ms_b, 6));
      chk("b_vulnerable", 32'(vb), exp_vul(ms_b));
      chk("b_round_win", 32'(rwb), 32'(ms_b.win));
      chk("b_rounds", 32'(rb), ms_b.rnd);
      chk("b_match_won", 32'(mb), 32'(ms_b.match));
    end
  end

  task automatic cyc(input bit r, input bit i, input bit d,
                     input logic [1:0] id);
    reset = r;
    increment = i;
    decrement = d;
    idle = id;
    @(negedge clk);
  endtask

  task automatic incs(input int k);
    for (int j = 0; j < k; j++) cyc(0, 1, 0, 2'b00);
  endtask

  initial begin
    int exp_b [5];
    exp_b = '{16, 32, 0, 0, 0};
    reset = 1; increment = 0; decrement = 0; idle = 0;
    @(negedge clk);
    cyc(1, 0, 0, 2'b00);
    chk("pin_reset_pattern", 32'(pa), 0);
    chk("pin_reset_vul", 32'(va), 1);
    chk("pin_reset_match", 32'(ma), 0);

    cyc(0, 1, 0, 2'b00);
    chk("pin_p1", 32'(pa), 8);
    chk("pin_v1", 32'(va), 1);
    cyc(0, 1, 0, 2'b00);
    chk("pin_p2", 32'(pa), 4);
    chk("pin_v2", 32'(va), 0);
    cyc(0, 1, 0, 2'b00);
    chk("pin_p3", 32'(pa), 2);
    cyc(0, 1, 0, 2'b00);
    chk("pin_p4", 32'(pa), 1);
    cyc(0, 1, 0, 2'b00);
    chk("pin_win1", 32'(rwa), 1);
    chk("pin_rounds1", 32'(ra), 1);
    cyc(0, 0, 0, 2'b00);
    chk("pin_after_win_pat", 32'(pa), 0);
    chk("pin_after_win_vul", 32'(va), 1);
    chk("pin_after_win_rw", 32'(rwa), 0);

    incs(2);
    chk("pin_pos2", 32'(pa), 4);
    for (int j = 0; j < 3; j++) begin
      cyc(0, 1, 0, 2'b01);
      chk("pin_frozen", 32'(pa), 4);
    end
    cyc(0, 1, 1, 2'b00);
    chk("pin_both_hold", 32'(pa), 4);
    cyc(0, 0, 1, 2'b00);
    chk("pin_dec1", 32'(pa), 8);
    cyc(0, 0, 1, 2'b00);
    cyc(0, 0, 1, 2'b00);
    chk("pin_no_underflow", 32'(pa), 0);

    incs(5);
    chk("pin_win2", 32'(rwa), 1);
    chk("pin_rounds2", 32'(ra), 2);
    cyc(0, 0, 0, 2'b00);
    for (int j = 0; j < 10; j++) begin
      chk("pin_match", 32'(ma), 1);
      chk("pin_match_pat", 32'(pa), 1);
      cyc(0, 1'($urandom), 1'($urandom), 2'($urandom));
    end

    cyc(1, 0, 0, 2'b00);
    incs(3);
    chk("pin_decay_p3", 32'(pb), 8);
    for (int j = 0; j < 5; j++) begin
      cyc(0, 0, 0, 2'b00);
      chk("pin_decay", 32'(pb), exp_b[j]);
    end
    chk("pin_decay_vul", 32'(vb), 1);

    cyc(1, 0, 0, 2'b00);
    incs(5);
    chk("pin_in_win", 32'(rwa), 1);
    cyc(1, 1, 0, 2'b11);
    chk("pin_rst_win_pat", 32'(pa), 0);
    chk("pin_rst_win_rounds", 32'(ra), 0);
    chk("pin_rst_win_vul", 32'(va), 1);
    incs(5);
    cyc(0, 0, 0, 2'b00);
    incs(5);
    cyc(0, 0, 0, 2'b00);
    chk("pin_in_match", 32'(ma), 1);
    cyc(1, 1, 0, 2'b10);
    chk("pin_rst_match", 32'(ma), 0);
    chk("pin_rst_match_rounds", 32'(ra), 0);
    chk("pin_rst_match_vul", 32'(va), 1);

    for (int j = 0; j < 3000; j++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) == 0,
          ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
